// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store unit: aligns EX memory ops onto a req/ack data bus, stalls until ack,
// returns extended load data. Define MEM_TIMEOUT_EN to add the bus-timeout counter and exc_buserr.
module mem_access_ctrl #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req_valid,
    input  logic [3:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic                flush,
    input  logic                stall_in,
    output logic                dbus_en,
    output logic [ADDR_W-1:0]   dbus_addr,
    output logic [DATA_W/8-1:0] dbus_wen,
    output logic [DATA_W-1:0]   dbus_wdata,
    input  logic [DATA_W-1:0]   dbus_rdata,
    input  logic                dbus_ack,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_rvalid,
    output logic                resnrdy,
    output logic                stallreq,
    output logic                exc_adel,
    output logic                exc_ades,
    output logic                exc_buserr
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DRAIN} state_e;

    state_e              state_q;
    logic                en_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [NB-1:0]       wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic                store_q;
    logic [OFF_W-1:0]    off_q;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                misalign;
    logic                accept;
    logic [OFF_W-1:0]    off;
    logic [NB-1:0]       size_mask;
    logic [NB-1:0]       wen_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   lane;
    logic [DATA_W-1:0]   ext;
    logic [DATA_W-1:0]   load_res;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned  CNT_W   = (TIMEOUT > 255) ? 16 : 8;
    localparam logic [CNT_W:0] TMO_LIM = (CNT_W + 1)'(TIMEOUT);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   cnt_inc;
    logic             tmo;
    logic             buserr_q;
    assign cnt_inc    = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign tmo        = (cnt_inc >= TMO_LIM);
    assign exc_buserr = buserr_q;
`else
    assign exc_buserr = 1'b0;
`endif

    assign off    = req_addr[OFF_W-1:0];
    assign addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        misalign  = 1'b0;
        size_mask = '1;
        wdata_d   = req_wdata;
        case (req_op[1:0])
            2'b00: begin
                size_mask = NB'(1);
                wdata_d   = {NB{req_wdata[7:0]}};
            end
            2'b01: begin
                misalign  = req_addr[0];
                size_mask = NB'(3);
                wdata_d   = {(NB/2){req_wdata[15:0]}};
            end
            2'b10: begin
                misalign  = |req_addr[1:0];
                size_mask = NB'(15);
                wdata_d   = {(NB/4){req_wdata[31:0]}};
            end
            default: misalign = (DATA_W == 32) ? 1'b1 : |req_addr[2:0];
        endcase
    end

    assign wen_d  = req_op[3] ? (size_mask << off) : '0;
    assign accept = (state_q == S_IDLE) && req_valid && !misalign && !flush;

    // Lane extraction uses the op captured at accept, since req_* may change while waiting.
    assign lane = dbus_rdata >> {off_q, 3'b000};

    always_comb begin
        ext = lane;
        case (size_q)
            2'b00:   ext = uns_q ? DATA_W'(lane[7:0])  : DATA_W'($signed(lane[7:0]));
            2'b01:   ext = uns_q ? DATA_W'(lane[15:0]) : DATA_W'($signed(lane[15:0]));
            2'b10:   ext = uns_q ? DATA_W'(lane[31:0]) : DATA_W'($signed(lane[31:0]));
            default: ext = lane;
        endcase
    end

    assign load_res = store_q ? '0 : ext;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            addr_q   <= '0;
            wen_q    <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            store_q  <= 1'b0;
            off_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= '0;
            buserr_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    state_q <= S_WAIT;
                    en_q    <= 1'b1;
                    addr_q  <= addr_d;
                    wen_q   <= wen_d;
                    wdata_q <= wdata_d;
                    size_q  <= req_op[1:0];
                    uns_q   <= req_op[2];
                    store_q <= req_op[3];
                    off_q   <= off;
`ifdef MEM_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                S_WAIT: begin
`ifdef MEM_TIMEOUT_EN
                    cnt_q <= cnt_inc[CNT_W-1:0];
`endif
                    if (dbus_ack) begin
                        en_q <= 1'b0;
                        if (flush) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q  <= S_DONE;
                            rvalid_q <= 1'b1;
                            rdata_q  <= load_res;
                        end
                    end else if (flush) begin
                        state_q <= S_DRAIN;
`ifdef MEM_TIMEOUT_EN
                    end else if (tmo) begin
                        en_q     <= 1'b0;
                        state_q  <= S_DONE;
                        rvalid_q <= 1'b1;
                        rdata_q  <= '0;
                        buserr_q <= 1'b1;
`endif
                    end
                end
                S_DONE: if (flush || !stall_in) begin
                    state_q  <= S_IDLE;
                    rvalid_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                    buserr_q <= 1'b0;
`endif
                end
                S_DRAIN: begin
`ifdef MEM_TIMEOUT_EN
                    cnt_q <= cnt_inc[CNT_W-1:0];
`endif
                    if (dbus_ack) begin
                        en_q    <= 1'b0;
                        state_q <= S_IDLE;
`ifdef MEM_TIMEOUT_EN
                    end else if (tmo) begin
                        en_q    <= 1'b0;
                        state_q <= S_IDLE;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            S_IDLE:  stallreq = accept;
            S_WAIT:  stallreq = 1'b1;
            S_DRAIN: stallreq = req_valid;
            default: stallreq = 1'b0;
        endcase
    end

    assign exc_adel   = (state_q == S_IDLE) && req_valid && misalign && !req_op[3];
    assign exc_ades   = (state_q == S_IDLE) && req_valid && misalign &&  req_op[3];
    assign resnrdy    = req_valid && !req_op[3] && (state_q != S_DONE);
    assign dbus_en    = en_q;
    assign dbus_addr  = addr_q;
    assign dbus_wen   = wen_q;
    assign dbus_wdata = wdata_q;
    assign mem_rvalid = rvalid_q;
    assign mem_rdata  = rdata_q;

endmodule
